// File: rtl/decoder3x8_strobe_pkg.sv
// decoder3x8_strobe_pkg: shared widths, state encodings and one-hot helper for the strobe decoder.
// The SCAN state exists only when DECODER_SCAN_EN is defined.
package decoder3x8_strobe_pkg;
    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 8;
`ifdef DECODER_SCAN_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_SCAN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1} state_t;
`endif
    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] c);
        return OUT_W'(1) << c;
    endfunction
endpackage

// File: rtl/decoder3x8_strobe_if.sv
// decoder3x8_strobe_if: code handshake and strobe outputs; scan_start only with DECODER_SCAN_EN.
interface decoder3x8_strobe_if;
    import decoder3x8_strobe_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] code;
    logic [OUT_W-1:0]  data;
    logic              busy;
    logic              done;
`ifdef DECODER_SCAN_EN
    logic              scan_start;
    modport master (output in_valid, code, scan_start, input in_ready, data, busy, done);
    modport slave  (input in_valid, code, scan_start, output in_ready, data, busy, done);
`else
    modport master (output in_valid, code, input in_ready, data, busy, done);
    modport slave  (input in_valid, code, output in_ready, data, busy, done);
`endif
endinterface

// File: rtl/decoder3x8_hold_cnt.sv
// decoder3x8_hold_cnt: 8-bit load/decrement dwell counter with a zero flag.
module decoder3x8_hold_cnt
    import decoder3x8_strobe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             cnt_zero
);
    logic [CNT_W-1:0] cnt;
    assign cnt_zero = (cnt == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !cnt_zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/decoder3x8_strobe.sv
// decoder3x8_strobe: clocked 3-to-8 decoder holding each one-hot value for HOLD cycles.
// Define DECODER_SCAN_EN to add the scan_start auto-walk of bit 0..7.
module decoder3x8_strobe
    import decoder3x8_strobe_pkg::*;
#(
    parameter int HOLD = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder3x8_strobe_if.slave  bus
);
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("decoder3x8_strobe: HOLD must be in 1..255");
    end
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
    state_t state;
    logic   cnt_zero;
    logic   accept;
    logic   finish;
    logic   load;
`ifdef DECODER_SCAN_EN
    logic [CODE_W-1:0] idx;
    logic              scan_go;
    logic              scan_step;
    assign bus.in_ready = (state == ST_IDLE) && !bus.scan_start;
    assign scan_go      = (state == ST_IDLE) && bus.scan_start;
    assign scan_step    = (state == ST_SCAN) && cnt_zero && (idx != 3'd7);
    assign finish       = cnt_zero && ((state == ST_HOLD) || ((state == ST_SCAN) && (idx == 3'd7)));
    assign load         = accept || scan_go || scan_step;
`else
    assign bus.in_ready = (state == ST_IDLE);
    assign finish       = cnt_zero && (state == ST_HOLD);
    assign load         = accept;
`endif
    assign accept   = bus.in_valid && bus.in_ready;
    assign bus.busy = (state != ST_IDLE);
    decoder3x8_hold_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .dec      (state != ST_IDLE),
        .load_val (HOLD_M1),
        .cnt_zero (cnt_zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bus.data <= '0;
            bus.done <= 1'b0;
`ifdef DECODER_SCAN_EN
            idx      <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
`ifdef DECODER_SCAN_EN
            if (scan_go) begin
                state    <= ST_SCAN;
                bus.data <= OUT_W'(1);
                idx      <= '0;
            end else if (scan_step) begin
                bus.data <= bus.data << 1;
                idx      <= idx + 1'b1;
            end else
`endif
            if (accept) begin
                state    <= ST_HOLD;
                bus.data <= onehot(bus.code);
            end else if (finish) begin
                state    <= ST_IDLE;
                bus.data <= '0;
                bus.done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_decoder3x8_strobe.sv
// tb_decoder3x8_strobe: directed checks of strobe timing, back-to-back, reset, exhaustive HOLD=255 and scan.
module tb_decoder3x8_strobe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    decoder3x8_strobe_if if_a ();
    decoder3x8_strobe_if if_b ();
    decoder3x8_strobe #(.HOLD(4))   u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    decoder3x8_strobe #(.HOLD(255)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
`ifdef DECODER_SCAN_EN
    decoder3x8_strobe_if if_c ();
    decoder3x8_strobe #(.HOLD(1))   u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
`endif
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] enc8x3(input logic [7:0] d);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (d[i]) r = 3'(i);
        return r;
    endfunction

    initial begin
        int n;
        int pulses;
        logic [7:0] first;
        if_a.in_valid = 1'b0; if_a.code = 3'd0;
        if_b.in_valid = 1'b0; if_b.code = 3'd0;
`ifdef DECODER_SCAN_EN
        if_a.scan_start = 1'b0; if_b.scan_start = 1'b0;
        if_c.in_valid = 1'b0; if_c.code = 3'd0; if_c.scan_start = 1'b0;
`endif
        step(); step();
        chk("rst data", 32'(if_a.data), 32'h00);
        chk("rst busy", 32'(if_a.busy), 32'd0);
        chk("rst ready", 32'(if_a.in_ready), 32'd1);
        chk("rst done", 32'(if_a.done), 32'd0);
        rst_n = 1'b1;
        step();
        // reset two cycles into a HOLD=4 strobe of code 5
        if_a.in_valid = 1'b1; if_a.code = 3'd5;
        step();
        if_a.in_valid = 1'b0;
        chk("mid accept data", 32'(if_a.data), 32'h20);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("mid rst data", 32'(if_a.data), 32'h00);
        chk("mid rst busy", 32'(if_a.busy), 32'd0);
        chk("mid rst ready", 32'(if_a.in_ready), 32'd1);
        #2 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (if_a.done) pulses++;
        end
        chk("mid rst no done", 32'(pulses), 32'd0);
        // single strobe, code 2
        if_a.in_valid = 1'b1; if_a.code = 3'd2;
        step();
        if_a.in_valid = 1'b0;
        n = 0;
        while (if_a.data == 8'h04 && if_a.in_ready == 1'b0 && if_a.done == 1'b0 && n < 20) begin
            n++;
            step();
        end
        chk("c2 hold cycles", 32'(n), 32'd4);
        chk("c2 end data", 32'(if_a.data), 32'h00);
        chk("c2 end done", 32'(if_a.done), 32'd1);
        chk("c2 end ready", 32'(if_a.in_ready), 32'd1);
        step();
        chk("c2 done once", 32'(if_a.done), 32'd0);
        // back-to-back with in_valid held; code changes while busy must be ignored
        if_a.in_valid = 1'b1; if_a.code = 3'd7;
        step();
        if_a.code = 3'd0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b 80 #%0d", i), 32'(if_a.data), 32'h80);
            step();
        end
        chk("b2b gap data", 32'(if_a.data), 32'h00);
        chk("b2b gap done", 32'(if_a.done), 32'd1);
        step();
        if_a.in_valid = 1'b0; if_a.code = 3'd3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b 01 #%0d", i), 32'(if_a.data), 32'h01);
            step();
        end
        chk("b2b end data", 32'(if_a.data), 32'h00);
        chk("b2b end done", 32'(if_a.done), 32'd1);
        step();
        // exhaustive codes with HOLD=255
        for (int c = 0; c < 8; c++) begin
            if_b.in_valid = 1'b1; if_b.code = 3'(c);
            step();
            if_b.in_valid = 1'b0;
            first = if_b.data;
            chk($sformatf("x%0d onehot", c), 32'(first), 32'h1 << c);
            chk($sformatf("x%0d encode", c), 32'(enc8x3(first)), 32'(c));
            n = 0;
            while (if_b.data == first && n < 300) begin
                n++;
                step();
            end
            chk($sformatf("x%0d len", c), 32'(n), 32'd255);
            chk($sformatf("x%0d done", c), 32'(if_b.done), 32'd1);
            step();
        end
`ifdef DECODER_SCAN_EN
        // scan_start wins over in_valid; code 4 must not be accepted
        if_c.scan_start = 1'b1; if_c.in_valid = 1'b1; if_c.code = 3'd4;
        #1;
        chk("scan ready low", 32'(if_c.in_ready), 32'd0);
        step();
        if_c.scan_start = 1'b0; if_c.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("scan step %0d", i), 32'(if_c.data), 32'h1 << i);
            chk($sformatf("scan busy %0d", i), 32'(if_c.busy), 32'd1);
            step();
        end
        chk("scan end data", 32'(if_c.data), 32'h00);
        chk("scan end done", 32'(if_c.done), 32'd1);
        chk("scan end busy", 32'(if_c.busy), 32'd0);
        step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
